// File: rtl/trace_replay_controller.sv
// Replays a branch trace from the trace ROM through a predictor handshake.
// Emits one training update per branch and keeps saturating hit/miss counters.
module trace_replay_controller #(
  parameter int unsigned ADDRESS_SIZE           = 8,
  parameter int unsigned TRAINING_DATA_SIZE     = 3898078,
  parameter int unsigned INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
  parameter int unsigned COUNT_WIDTH            = 32
) (
  input  logic                              Clk,
  input  logic                              reset,
  input  logic                              start,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] InstructionNumber,
  input  logic [ADDRESS_SIZE-1:0]           TraceAddress,
  input  logic                              TraceResult,
  output logic                              PredReq,
  output logic [ADDRESS_SIZE-1:0]           PredAddress,
  input  logic                              PredValid,
  input  logic                              PredTaken,
  output logic                              UpdateValid,
  output logic [ADDRESS_SIZE-1:0]           UpdateAddress,
  output logic                              UpdateTaken,
  output logic                              UpdateMispredict,
  output logic                              Busy,
  output logic                              Done,
  output logic [COUNT_WIDTH-1:0]            CorrectCount,
  output logic [COUNT_WIDTH-1:0]            MispredictCount
);

  localparam logic [INSTRUCTION_INDEX_SIZE-1:0] LAST_INDEX =
    INSTRUCTION_INDEX_SIZE'(TRAINING_DATA_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_REQ    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e                            state_q, state_d;
  logic [INSTRUCTION_INDEX_SIZE-1:0] instr_q, instr_d;
  logic [ADDRESS_SIZE-1:0]           pred_addr_q, pred_addr_d;
  logic                              outcome_q, outcome_d;
  logic                              pred_req_q, pred_req_d;
  logic                              upd_valid_q, upd_valid_d;
  logic [ADDRESS_SIZE-1:0]           upd_addr_q, upd_addr_d;
  logic                              upd_taken_q, upd_taken_d;
  logic                              upd_misp_q, upd_misp_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [COUNT_WIDTH-1:0]            correct_q, correct_d;
  logic [COUNT_WIDTH-1:0]            misp_cnt_q, misp_cnt_d;

  // Next state and registered-output values; status flags are decoded from state_d.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pred_addr_d = pred_addr_q;
    outcome_d   = outcome_q;
    upd_addr_d  = upd_addr_q;
    upd_taken_d = upd_taken_q;
    upd_misp_d  = upd_misp_q;
    correct_d   = correct_q;
    misp_cnt_d  = misp_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          instr_d    = '0;
          correct_d  = '0;
          misp_cnt_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        pred_addr_d = TraceAddress;
        outcome_d   = TraceResult;
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        if (PredValid) begin
          upd_addr_d  = pred_addr_q;
          upd_taken_d = outcome_q;
          upd_misp_d  = (PredTaken != outcome_q);
          state_d     = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // Saturating statistics: hold at all-ones rather than wrap.
        if (upd_misp_q) begin
          if (misp_cnt_q != '1) misp_cnt_d = misp_cnt_q + COUNT_WIDTH'(1);
        end else begin
          if (correct_q != '1) correct_d = correct_q + COUNT_WIDTH'(1);
        end
        if (instr_q == LAST_INDEX) begin
          state_d = ST_DONE;
        end else begin
          instr_d = instr_q + INSTRUCTION_INDEX_SIZE'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pred_req_d  = (state_d == ST_REQ);
    upd_valid_d = (state_d == ST_UPDATE);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      pred_addr_q <= '0;
      outcome_q   <= 1'b0;
      pred_req_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_taken_q <= 1'b0;
      upd_misp_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      correct_q   <= '0;
      misp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pred_addr_q <= pred_addr_d;
      outcome_q   <= outcome_d;
      pred_req_q  <= pred_req_d;
      upd_valid_q <= upd_valid_d;
      upd_addr_q  <= upd_addr_d;
      upd_taken_q <= upd_taken_d;
      upd_misp_q  <= upd_misp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      correct_q   <= correct_d;
      misp_cnt_q  <= misp_cnt_d;
    end
  end

  assign InstructionNumber = instr_q;
  assign PredReq           = pred_req_q;
  assign PredAddress       = pred_addr_q;
  assign UpdateValid       = upd_valid_q;
  assign UpdateAddress     = upd_addr_q;
  assign UpdateTaken       = upd_taken_q;
  assign UpdateMispredict  = upd_misp_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign CorrectCount      = correct_q;
  assign MispredictCount   = misp_cnt_q;

endmodule

// File: tb/tb_trace_replay_controller.sv
// Directed bench: a 4-branch trace with an always-taken predictor, plus a
// second instance with 2-bit counters and 6 branches for saturation.
module tb_trace_replay_controller;

  localparam int unsigned AW  = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned CW  = 32;
  localparam int unsigned NS  = 6;
  localparam int unsigned IWS = 3;
  localparam int unsigned CWS = 2;

  int total = 0;
  int bad   = 0;

  logic Clk   = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  logic          start, PredValid, PredTaken;
  logic [AW-1:0] TraceAddress;
  logic          TraceResult;
  logic [IW-1:0] InstructionNumber;
  logic          PredReq, UpdateValid, UpdateTaken, UpdateMispredict, Busy, Done;
  logic [AW-1:0] PredAddress, UpdateAddress;
  logic [CW-1:0] CorrectCount, MispredictCount;

  logic           start_s, PredValid_s, PredTaken_s;
  logic [AW-1:0]  TraceAddress_s;
  logic           TraceResult_s;
  logic [IWS-1:0] InstructionNumber_s;
  logic           PredReq_s, UpdateValid_s, UpdateTaken_s, UpdateMispredict_s, Busy_s, Done_s;
  logic [AW-1:0]  PredAddress_s, UpdateAddress_s;
  logic [CWS-1:0] CorrectCount_s, MispredictCount_s;

  logic [AW-1:0] rom_addr [N] = '{8'h3C, 8'hA5, 8'h07, 8'hF0};
  logic          rom_out  [N] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic          exp_misp [N] = '{1'b0, 1'b1, 1'b0, 1'b0};

  trace_replay_controller #(
    .ADDRESS_SIZE(AW), .TRAINING_DATA_SIZE(N), .INSTRUCTION_INDEX_SIZE(IW), .COUNT_WIDTH(CW)
  ) dut (
    .Clk(Clk), .reset(reset), .start(start), .InstructionNumber(InstructionNumber),
    .TraceAddress(TraceAddress), .TraceResult(TraceResult), .PredReq(PredReq),
    .PredAddress(PredAddress), .PredValid(PredValid), .PredTaken(PredTaken),
    .UpdateValid(UpdateValid), .UpdateAddress(UpdateAddress), .UpdateTaken(UpdateTaken),
    .UpdateMispredict(UpdateMispredict), .Busy(Busy), .Done(Done),
    .CorrectCount(CorrectCount), .MispredictCount(MispredictCount)
  );

  trace_replay_controller #(
    .ADDRESS_SIZE(AW), .TRAINING_DATA_SIZE(NS), .INSTRUCTION_INDEX_SIZE(IWS), .COUNT_WIDTH(CWS)
  ) dut_s (
    .Clk(Clk), .reset(reset), .start(start_s), .InstructionNumber(InstructionNumber_s),
    .TraceAddress(TraceAddress_s), .TraceResult(TraceResult_s), .PredReq(PredReq_s),
    .PredAddress(PredAddress_s), .PredValid(PredValid_s), .PredTaken(PredTaken_s),
    .UpdateValid(UpdateValid_s), .UpdateAddress(UpdateAddress_s), .UpdateTaken(UpdateTaken_s),
    .UpdateMispredict(UpdateMispredict_s), .Busy(Busy_s), .Done(Done_s),
    .CorrectCount(CorrectCount_s), .MispredictCount(MispredictCount_s)
  );

  // Trace ROM models with one cycle of registered read latency.
  always @(posedge Clk) begin
    TraceAddress   <= rom_addr[InstructionNumber];
    TraceResult    <= rom_out[InstructionNumber];
    TraceAddress_s <= 8'h40 + 8'(InstructionNumber_s);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_idx"},   64'(InstructionNumber), 64'(0));
    check({tag, "_preq"},  64'(PredReq), 64'(0));
    check({tag, "_paddr"}, 64'(PredAddress), 64'(0));
    check({tag, "_uv"},    64'(UpdateValid), 64'(0));
    check({tag, "_uaddr"}, 64'(UpdateAddress), 64'(0));
    check({tag, "_utkn"},  64'(UpdateTaken), 64'(0));
    check({tag, "_umisp"}, 64'(UpdateMispredict), 64'(0));
    check({tag, "_busy"},  64'(Busy), 64'(0));
    check({tag, "_done"},  64'(Done), 64'(0));
    check({tag, "_cc"},    64'(CorrectCount), 64'(0));
    check({tag, "_mc"},    64'(MispredictCount), 64'(0));
  endtask

  // Full replay of the 4-branch trace; branch stall_br gets stall_n wait cycles.
  task automatic run_trace(input int stall_br, input int stall_n, input bit spur);
    int cyc, idx, req_cnt, want_req;
    logic prev_uv;
    logic [AW-1:0] held;
    start = 1'b1; PredValid = 1'b0; PredTaken = 1'b0;
    tick();
    start = 1'b0;
    check("start_busy", 64'(Busy), 64'(1));
    check("start_done", 64'(Done), 64'(0));
    check("start_idx",  64'(InstructionNumber), 64'(0));
    check("start_cc",   64'(CorrectCount), 64'(0));
    check("start_mc",   64'(MispredictCount), 64'(0));
    cyc = 1; idx = 0; req_cnt = 0; prev_uv = 1'b0; held = '0;
    while (Done !== 1'b1 && cyc < 200) begin
      start = 1'b0; PredValid = 1'b0; PredTaken = 1'b0;
      want_req = (idx == stall_br) ? stall_n + 1 : 1;
      if (PredReq === 1'b1) begin
        req_cnt++;
        if (req_cnt == 1) held = PredAddress;
        else check("stall_addr_const", 64'(PredAddress), 64'(held));
        check("req_no_uv", 64'(UpdateValid), 64'(0));
        if (idx < int'(N)) check("req_addr", 64'(PredAddress), 64'(rom_addr[idx]));
        if (req_cnt >= want_req) begin PredValid = 1'b1; PredTaken = 1'b1; end
      end
      if (UpdateValid === 1'b1) begin
        check("uv_not_back_to_back", 64'(prev_uv), 64'(0));
        check("req_len", 64'(req_cnt), 64'(want_req));
        if (idx < int'(N)) begin
          check("upd_addr",  64'(UpdateAddress), 64'(rom_addr[idx]));
          check("upd_taken", 64'(UpdateTaken), 64'(rom_out[idx]));
          check("upd_misp",  64'(UpdateMispredict), 64'(exp_misp[idx]));
          check("upd_index", 64'(InstructionNumber), 64'(idx));
        end else begin
          check("update_count_overflow", 64'(idx), 64'(N - 1));
        end
        idx++; req_cnt = 0;
      end
      if (spur && (UpdateValid === 1'b1 || (prev_uv && Busy === 1'b1))) begin
        start = 1'b1; PredValid = 1'b1; PredTaken = 1'b0;
      end
      check("busy_done_excl", 64'(Busy & Done), 64'(0));
      prev_uv = UpdateValid;
      tick();
      cyc++;
    end
    start = 1'b0; PredValid = 1'b0; PredTaken = 1'b0;
    check("done_cycle", 64'(cyc), 64'(4 * N + 1 + ((stall_br < int'(N)) ? stall_n : 0)));
    check("num_updates", 64'(idx), 64'(N));
    check("final_cc", 64'(CorrectCount), 64'(3));
    check("final_mc", 64'(MispredictCount), 64'(1));
    check("final_idx", 64'(InstructionNumber), 64'(N - 1));
    check("final_busy", 64'(Busy), 64'(0));
  endtask

  initial begin
    int cyc, ucnt;
    start = 1'b0; PredValid = 1'b0; PredTaken = 1'b0;
    start_s = 1'b0; PredValid_s = 1'b0; PredTaken_s = 1'b1; TraceResult_s = 1'b1;

    // Reset held with random stimulus, then released with start low.
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); PredValid = 1'($urandom); PredTaken = 1'($urandom);
      tick();
      if (i == 5) check_reset_outs("rst_hold");
    end
    start = 1'b0; PredValid = 1'b0; PredTaken = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PredValid = 1'($urandom); PredTaken = 1'($urandom);
      tick();
      check("post_rst_busy", 64'(Busy), 64'(0));
      check("post_rst_done", 64'(Done), 64'(0));
    end
    PredValid = 1'b0; PredTaken = 1'b0;

    run_trace(99, 0, 1'b0);
    run_trace(99, 0, 1'b0);
    run_trace(1, 5, 1'b0);
    run_trace(99, 0, 1'b1);

    // Abort during the third branch's request phase.
    start = 1'b1; tick(); start = 1'b0;
    ucnt = 0; cyc = 0;
    while (!(PredReq === 1'b1 && ucnt == 2) && cyc < 100) begin
      if (UpdateValid === 1'b1) ucnt++;
      PredValid = PredReq; PredTaken = 1'b1;
      if (PredReq === 1'b1 && ucnt == 2) PredValid = 1'b0;
      tick();
      cyc++;
    end
    PredValid = 1'b0;
    check("midrst_reached_req", 64'(PredReq), 64'(1));
    #2 reset = 1'b0;
    #1 check_reset_outs("midrst");
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PredValid = 1'b1;
      tick();
      check("midrst_no_uv", 64'(UpdateValid), 64'(0));
      check("midrst_idle", 64'(Busy), 64'(0));
    end
    PredValid = 1'b0;
    run_trace(99, 0, 1'b0);

    // Saturating counter instance: every prediction correct.
    start_s = 1'b1; tick(); start_s = 1'b0;
    cyc = 1;
    while (Done_s !== 1'b1 && cyc < 200) begin
      PredValid_s = PredReq_s;
      tick();
      cyc++;
    end
    PredValid_s = 1'b0;
    check("sat_done_cycle", 64'(cyc), 64'(4 * NS + 1));
    check("sat_cc", 64'(CorrectCount_s), 64'(3));
    check("sat_mc", 64'(MispredictCount_s), 64'(0));
    check("sat_idx", 64'(InstructionNumber_s), 64'(NS - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
